// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor: d = a - b - bin (mod 2^WIDTH), one bit per clock, LSB first.
// Results and borrow-out are published only at completion; partial results stay internal.
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sh_q, sh_d, d_q, d_d;
  logic              br_q, br_d, bout_q, bout_d, done_q, done_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic              abit, bbit, dbit, br_next;
  logic [WIDTH-1:0]  sh_next;

  // Full-subtractor stage on the currently indexed bit pair.
  always_comb begin
    abit    = a_q[idx_q];
    bbit    = b_q[idx_q];
    dbit    = abit ^ bbit ^ br_q;
    br_next = (~abit & bbit) | (~abit & br_q) | (bbit & br_q);
    sh_next = {dbit, sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          sh_d    = '0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sh_d  = sh_next;
        br_d  = br_next;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          d_d     = sh_next;
          bout_d  = br_next;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = done_q;
    d    = d_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed table at WIDTH=4, corner sequences, and a
// randomized WIDTH=8 sweep against an integer-arithmetic reference.
module tb_serial_sub;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, d4;
  logic       rst8, start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, d8;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .bout(bout4)
  );

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] exp_d;
    logic       exp_bout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; issues one request and returns at the negedge where done is seen.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                     output int busy_cnt, output int lat, output logic got, output logic held);
    logic [3:0] d_before;
    logic       bout_before;
    d_before    = d4;
    bout_before = bout4;
    held   = 1'b1;
    start4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    busy_cnt = 0;
    lat      = 1;
    while (!done4 && lat < 20) begin
      if (busy4) busy_cnt++;
      if (d4 !== d_before || bout4 !== bout_before) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    got = done4;
  endtask

  vec_t vecs[6];
  int   busy_cnt, lat, dones;
  logic got, held;

  initial begin
    vecs[0] = '{a: 4'd9,  b: 4'd5,  bin: 1'b0, exp_d: 4'd4,  exp_bout: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, exp_d: 4'd14, exp_bout: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, exp_d: 4'd15, exp_bout: 1'b1};
    vecs[3] = '{a: 4'd15, b: 4'd15, bin: 1'b1, exp_d: 4'd15, exp_bout: 1'b1};
    vecs[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, exp_d: 4'd15, exp_bout: 1'b0};
    vecs[5] = '{a: 4'd6,  b: 4'd1,  bin: 1'b0, exp_d: 4'd5,  exp_bout: 1'b0};

    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (2) @(negedge clk);
    rst4 = 1'b0; rst8 = 1'b0;
    chk("reset busy", 32'(busy4), 0);
    chk("reset done", 32'(done4), 0);
    chk("reset d", 32'(d4), 0);
    chk("reset bout", 32'(bout4), 0);
    chk("reset busy8", 32'(busy8), 0);

    // Directed table.
    foreach (vecs[i]) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].bin, busy_cnt, lat, got, held);
      chk($sformatf("vec%0d done", i), 32'(got), 1);
      chk($sformatf("vec%0d d", i), 32'(d4), 32'(vecs[i].exp_d));
      chk($sformatf("vec%0d bout", i), 32'(bout4), 32'(vecs[i].exp_bout));
      chk($sformatf("vec%0d busy cycles", i), 32'(busy_cnt), 4);
      chk($sformatf("vec%0d latency", i), 32'(lat), 5);
      chk($sformatf("vec%0d outputs held", i), 32'(held), 1);
      @(negedge clk);
      chk($sformatf("vec%0d done one cycle", i), 32'(done4), 0);
      chk($sformatf("vec%0d busy after", i), 32'(busy4), 0);
    end

    // START while busy is ignored.
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd5; bin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(negedge clk);
    start4 = 1'b0;
    dones = 0;
    repeat (12) begin
      if (done4) dones++;
      @(negedge clk);
    end
    chk("ignored start dones", 32'(dones), 1);
    chk("ignored start d", 32'(d4), 4);
    chk("ignored start busy", 32'(busy4), 0);

    // Back-to-back: second request in the DONE cycle.
    op4(4'd7, 4'd2, 1'b0, busy_cnt, lat, got, held);
    chk("b2b first d", 32'(d4), 5);
    chk("b2b first done", 32'(got), 1);
    op4(4'd2, 4'd7, 1'b0, busy_cnt, lat, got, held);
    chk("b2b second done", 32'(got), 1);
    chk("b2b second latency", 32'(lat), 5);
    chk("b2b second d", 32'(d4), 11);
    chk("b2b second bout", 32'(bout4), 1);
    @(negedge clk);

    // Reset aborts an in-flight operation.
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd5; bin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    chk("abort busy", 32'(busy4), 0);
    chk("abort d", 32'(d4), 0);
    chk("abort bout", 32'(bout4), 0);
    dones = 0;
    repeat (8) begin
      if (done4) dones++;
      @(negedge clk);
    end
    chk("abort no done", 32'(dones), 0);
    op4(4'd6, 4'd1, 1'b0, busy_cnt, lat, got, held);
    chk("post abort done", 32'(got), 1);
    chk("post abort d", 32'(d4), 5);
    chk("post abort bout", 32'(bout4), 0);

    // Randomized WIDTH=8 sweep.
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra, rb;
      logic       rbin;
      int         diff, cnt, k;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (n % 50 == 0) begin ra = 8'd0; rb = 8'd255; rbin = 1'b1; end
      diff = int'(ra) - int'(rb) - int'(rbin);
      start8 = 1'b1; a8 = ra; b8 = rb; bin8 = rbin;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      cnt = 0; k = 0;
      while (!done8 && k < 30) begin
        if (busy8) cnt++;
        @(negedge clk);
        k++;
      end
      chk("rnd done", 32'(done8), 1);
      chk("rnd d", 32'(d8), 32'(diff & 8'hff));
      chk("rnd bout", 32'(bout8), 32'(diff < 0));
      chk("rnd adder identity", 32'((int'(d8) + int'(rb) + int'(rbin)) & 8'hff), 32'(ra));
      chk("rnd busy cycles", 32'(cnt), 8);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial ripple-borrow subtractor. It is the inverse-direction companion to the team's combinational ripple-carry adder.
- Computes D = A - B - BIN modulo 2^WIDTH, plus a borrow-out, one bit per clock, LSB first.
- Each bit uses a full-subtractor stage: d = a^b^br, br' = (~a&b)|(~a&br)|(b&br).
- Used where area matters more than latency. Its results are cross-checkable against the adder, since A == D + B + BIN (mod 2^WIDTH).

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on accepted START.
- B  input  WIDTH  subtrahend; captured on accepted START.
- BIN  input  1  borrow-in; captured on accepted START.
- BUSY  output  1  high while a subtraction is in progress.
- DONE  output  1  one-cycle pulse when D/BOUT are updated.
- D  output  WIDTH  difference; holds its last result.
- BOUT  output  1  borrow-out of the MSB stage; holds its last result.

Behaviour:
- Reset: one clock, synchronous, active-high. When RST is sampled high:
  - state=IDLE;
  - BUSY=0, DONE=0, D=0, BOUT=0;
  - internal operand, shift, borrow and bit-index registers = 0.
- RST has priority over every other input, including an in-flight operation. An aborted operation never raises DONE.
- States: IDLE, RUN.
- IDLE:
  - DONE is 0 except in the cycle immediately after a completion.
  - START=1 at edge k: latch A, B and BIN (BIN into the borrow register), clear the index, move to RUN. BUSY=1 after edge k.
  - START=0: remain in IDLE; D and BOUT hold.
- RUN:
  - At each edge, process bit[idx] of the latched A and B with the current borrow.
  - Shift d into the result register at the MSB end, with a right-shift, so that bit0 ends up at D[0].
  - Update the borrow and increment idx.
  - At the edge that processes bit WIDTH-1, edge k+WIDTH:
    - D <= full result;
    - BOUT <= final borrow;
    - DONE <= 1, BUSY <= 0;
    - state <= IDLE.
- Latency: START accepted at edge k; result visible, with DONE=1, after edge k+WIDTH. That is WIDTH cycles of BUSY, then one DONE cycle.
- DONE stays high for exactly one cycle and is cleared at the next edge.
- START while BUSY=1 is ignored. The operand inputs are don't-care while BUSY.
- START during the DONE cycle is legal, because the block is already in IDLE. That gives back-to-back operations with a throughput of one result per WIDTH+1 cycles.
- A, B and BIN may change freely after the accepting edge; only the latched copies are used.
- D and BOUT change only at completion or reset, never mid-operation. Partial results stay internal.
- Arithmetic:
  - D = (A - B - BIN) mod 2^WIDTH.
  - BOUT = 1 iff A < B + BIN, compared as unsigned with WIDTH+1 bits.
- Operands are unsigned. For signed use, overflow detection is left to the consumer.

Test Plan:
1. WIDTH=4, reset, then START with A=9, B=5, BIN=0 -> BUSY high for 4 cycles; DONE pulses for one cycle at cycle 5; D=4, BOUT=0.
2. A=3, B=5, BIN=0 -> D=14, BOUT=1. Then A=0, B=0, BIN=1 -> D=15, BOUT=1. Then A=15, B=15, BIN=1 -> D=15, BOUT=1. Then A=15, B=0, BIN=0 -> D=15, BOUT=0.
3. START with A=9, B=5. Pulse START again with A=1, B=1 on the 2nd BUSY cycle -> the second request is ignored; single DONE; D=4.
4. Back-to-back requests:
   - A=7, B=2 completes, D=5.
   - START with A=2, B=7 asserted during that DONE cycle is accepted.
   - Second DONE comes exactly 5 cycles later with D=11, BOUT=1.
   - No idle gap is needed.
5. START with A=9, B=5. Assert RST on BUSY cycle 2 -> next cycle BUSY=0, D=0, BOUT=0; DONE never asserts. A subsequent START with A=6, B=1 gives D=5 normally.
6. WIDTH=8 random sweep:
   - ≥1000 operations with random A, B, BIN and random START gaps.
   - Each DONE must give D == (A-B-BIN) & 0xFF.
   - BOUT must equal the unsigned compare.
   - The adder identity D + B + BIN == A (mod 256) must hold.
   - Every result must take exactly 8 BUSY cycles.
